// File: rtl/run_controller.sv
// run_controller
// Run-control block for the SimpleRISC core. It stretches reset into the core, gates
// the core clock-enable, counts enabled cycles, and ends a run on a halt or when the
// cycle budget runs out. It also provides pause, single-step and a synchronous soft restart.
//
// Ports
//   clk          in   1      system clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   soft_rst     in   1      synchronous restart request, active-high
//   halt_in      in   1      halt-instruction retirement from the core (used only when enabled)
//   pause        in   1      level: freeze the core while high
//   step         in   1      rising edge while paused grants one enabled cycle
//   core_rst     out  1      registered active-high reset to the core
//   core_en      out  1      core clock-enable (combinational from state/pause/step)
//   cycle_count  out  CNT_W  enabled cycles completed, wraps
//   run_state    out  3      HOLD=0 RUN=1 PAUSE=2 HALTED=3 TIMEOUT=4
//   done         out  1      registered; high in HALTED or TIMEOUT
//   timeout      out  1      registered; high only in TIMEOUT
module run_controller #(
   parameter int unsigned RST_CYCLES = 2,
   parameter int unsigned MAX_CYCLES = 15,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             soft_rst,
   input  logic             halt_in,
   input  logic             pause,
   input  logic             step,
   output logic             core_rst,
   output logic             core_en,
   output logic [CNT_W-1:0] cycle_count,
   output logic [2:0]       run_state,
   output logic             done,
   output logic             timeout
);

   typedef enum logic [2:0] {
      ST_HOLD    = 3'd0,
      ST_RUN     = 3'd1,
      ST_PAUSE   = 3'd2,
      ST_HALTED  = 3'd3,
      ST_TIMEOUT = 3'd4
   } state_t;

   localparam int unsigned       HOLD_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]  BUDGET_LAST = CNT_W'(MAX_CYCLES - 1);

   state_t            state_r;
   logic [HOLD_W-1:0] hold_cnt_r;
   logic              step_q_r;
   logic              core_rst_r;
   logic [CNT_W-1:0]  cycle_count_r;
   logic              done_r;
   logic              timeout_r;

   logic              step_pulse_s;
   logic              core_en_s;
   logic              budget_hit_s;

   // Enable decode: free-running in RUN, one cycle per step edge in PAUSE.
   always_comb begin
      step_pulse_s = step & ~step_q_r;
      core_en_s    = 1'b0;
      budget_hit_s = 1'b0;
      if (state_r == ST_RUN) begin
         core_en_s = ~pause;
      end else if (state_r == ST_PAUSE) begin
         core_en_s = step_pulse_s;
      end else begin
         core_en_s = 1'b0;
      end
      // A zero budget disables the timeout entirely.
      if (MAX_CYCLES != 0) begin
         budget_hit_s = (cycle_count_r == BUDGET_LAST);
      end else begin
         budget_hit_s = 1'b0;
      end
   end

   // Run-control state machine with its registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_HOLD;
         hold_cnt_r    <= '0;
         step_q_r      <= 1'b0;
         core_rst_r    <= 1'b1;
         cycle_count_r <= '0;
         done_r        <= 1'b0;
         timeout_r     <= 1'b0;
      end else begin
         step_q_r <= step;
         if (soft_rst) begin
            state_r       <= ST_HOLD;
            hold_cnt_r    <= '0;
            core_rst_r    <= 1'b1;
            cycle_count_r <= '0;
            done_r        <= 1'b0;
            timeout_r     <= 1'b0;
         end else begin
            if (core_en_s) begin
               cycle_count_r <= cycle_count_r + CNT_W'(1);
            end
            case (state_r)
               ST_HOLD: begin
                  // Release the core on the same edge the hold count completes.
                  if (hold_cnt_r == HOLD_LAST) begin
                     state_r    <= ST_RUN;
                     core_rst_r <= 1'b0;
                     hold_cnt_r <= '0;
                  end else begin
                     hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                  end
               end
               ST_RUN, ST_PAUSE: begin
                  // Halt beats timeout when both land on the last budget cycle.
                  if (core_en_s && halt_in) begin
                     state_r <= ST_HALTED;
                     done_r  <= 1'b1;
                  end else if (core_en_s && budget_hit_s) begin
                     state_r   <= ST_TIMEOUT;
                     done_r    <= 1'b1;
                     timeout_r <= 1'b1;
                  end else if (pause) begin
                     state_r <= ST_PAUSE;
                  end else begin
                     state_r <= ST_RUN;
                  end
               end
               ST_HALTED, ST_TIMEOUT: begin
                  state_r <= state_r;
               end
               default: begin
                  state_r    <= ST_HOLD;
                  hold_cnt_r <= '0;
                  core_rst_r <= 1'b1;
               end
            endcase
         end
      end
   end

   assign core_rst    = core_rst_r;
   assign core_en     = core_en_s;
   assign cycle_count = cycle_count_r;
   assign run_state   = state_r;
   assign done        = done_r;
   assign timeout     = timeout_r;

endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller
// Self-checking bench for run_controller. A behavioural model tracks the run as
// "reset edges still owed", "enabled cycles so far", "halted", "timed out" and
// "paused", and the expected outputs are derived from those facts.
module tb_run_controller;

   localparam int RST  = 2;
   localparam int MAXC = 15;
   localparam int CW   = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          soft_rst;
   logic          halt_in;
   logic          pause;
   logic          step;
   logic          core_rst;
   logic          core_en;
   logic [CW-1:0] cycle_count;
   logic [2:0]    run_state;
   logic          done;
   logic          timeout;

   int total = 0;
   int bad   = 0;

   // behavioural model
   int          m_hold_left;
   int unsigned m_count;
   bit          m_halted;
   bit          m_timed;
   bit          m_paused;
   bit          m_prev_step;

   run_controller #(.RST_CYCLES(RST), .MAX_CYCLES(MAXC), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst), .halt_in(halt_in),
      .pause(pause), .step(step), .core_rst(core_rst), .core_en(core_en),
      .cycle_count(cycle_count), .run_state(run_state), .done(done), .timeout(timeout)
   );

   always #5 clk = ~clk;

   function automatic logic exp_en();
      if (m_hold_left > 0 || m_halted || m_timed) return 1'b0;
      if (m_paused) return step && !m_prev_step;
      return !pause;
   endfunction

   function automatic logic [2:0] exp_state();
      if (m_hold_left > 0) return 3'd0;
      if (m_halted)        return 3'd3;
      if (m_timed)         return 3'd4;
      if (m_paused)        return 3'd2;
      return 3'd1;
   endfunction

   function automatic logic [CW+6:0] exp_vec();
      return {(m_hold_left > 0), exp_en(), exp_state(), (m_halted | m_timed), m_timed, CW'(m_count)};
   endfunction

   function automatic logic [CW+6:0] obs_vec();
      return {core_rst, core_en, run_state, done, timeout, cycle_count};
   endfunction

   task automatic model_reset();
      m_hold_left = RST; m_count = 0; m_halted = 0; m_timed = 0; m_paused = 0; m_prev_step = 0;
   endtask

   task automatic model_edge();
      bit en;
      en = exp_en();
      m_prev_step = step;
      if (soft_rst) begin
         m_hold_left = RST; m_count = 0; m_halted = 0; m_timed = 0; m_paused = 0;
      end else if (m_hold_left > 0) begin
         m_hold_left--;
      end else if (!m_halted && !m_timed) begin
         if (en) m_count++;
         if (en && halt_in)                          m_halted = 1;
         else if (en && MAXC != 0 && m_count == MAXC) m_timed  = 1;
         else                                          m_paused = pause;
      end
   endtask

   task automatic advance();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic restart();
      soft_rst = 1'b1; pause = 1'b0; step = 1'b0; halt_in = 1'b0;
      advance();
      soft_rst = 1'b0;
   endtask

   task automatic run_to(input int unsigned target);
      for (int g = 0; g < 60 && !(m_count == target && m_hold_left == 0); g++) advance();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; soft_rst = 1'b0; halt_in = 1'b0; pause = 1'b0; step = 1'b0;
      model_reset();
      #6;
      total++;
      if (obs_vec() !== exp_vec()) begin
         $display("FAIL reset_vec: got %h want %h", obs_vec(), exp_vec()); bad++;
      end
      total++;
      if (core_rst !== 1'b1 || core_en !== 1'b0 || cycle_count !== 32'd0) begin
         $display("FAIL reset_vals: got rst=%b en=%b cnt=%0d want 1 0 0", core_rst, core_en, cycle_count); bad++;
      end
      #1 rst_n = 1'b1;
   endtask

   task automatic test_startup();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         total++;
         if (core_rst !== 1'b1) begin
            $display("FAIL startup_hold%0d: got core_rst=%b want 1", i, core_rst); bad++;
         end
         advance();
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (core_rst !== 1'b0 || core_en !== 1'b1 || cycle_count !== CW'(i)) begin
            $display("FAIL startup_run%0d: got rst=%b en=%b cnt=%0d want 0 1 %0d", i, core_rst, core_en, cycle_count, i); bad++;
         end
         advance();
      end
   endtask

   task automatic test_timeout();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         total++;
         if (obs_vec() !== exp_vec()) begin
            $display("FAIL timeout_cyc%0d: got %h want %h", i, obs_vec(), exp_vec()); bad++;
         end
         advance();
      end
      total++;
      if (run_state !== 3'd4 || cycle_count !== 32'd15 || done !== 1'b1 || timeout !== 1'b1 || core_en !== 1'b0) begin
         $display("FAIL timeout_final: got st=%0d cnt=%0d done=%b to=%b en=%b want 4 15 1 1 0",
                  run_state, cycle_count, done, timeout, core_en); bad++;
      end
   endtask

   task automatic test_halt(input int unsigned hc);
      restart();
      run_to(hc);
      halt_in = 1'b1;
      @(negedge clk);
      total++;
      if (obs_vec() !== exp_vec()) begin
         $display("FAIL halt%0d_pre: got %h want %h", hc, obs_vec(), exp_vec()); bad++;
      end
      advance();
      halt_in = 1'b0;
      total++;
      if (run_state !== 3'd3 || cycle_count !== CW'(hc + 1) || done !== 1'b1 || timeout !== 1'b0) begin
         $display("FAIL halt%0d_final: got st=%0d cnt=%0d done=%b to=%b want 3 %0d 1 0",
                  hc, run_state, cycle_count, done, timeout, hc + 1); bad++;
      end
      for (int i = 0; i < 5; i++) begin
         pause = 1'($urandom_range(0, 1)); step = 1'($urandom_range(0, 1)); halt_in = 1'($urandom_range(0, 1));
         @(negedge clk);
         total++;
         if (obs_vec() !== exp_vec()) begin
            $display("FAIL halt%0d_hold%0d: got %h want %h", hc, i, obs_vec(), exp_vec()); bad++;
         end
         advance();
      end
      pause = 1'b0; step = 1'b0; halt_in = 1'b0;
   endtask

   task automatic test_pause_step();
      int pat [6] = '{0, 1, 0, 1, 1, 1};
      restart();
      run_to(3);
      pause = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step = 1'(pat[i]);
         @(negedge clk);
         total++;
         if (obs_vec() !== exp_vec()) begin
            $display("FAIL pause_cyc%0d: got %h want %h", i, obs_vec(), exp_vec()); bad++;
         end
         advance();
      end
      pause = 1'b0; step = 1'b0;
      total++;
      if (cycle_count !== 32'd5 || run_state !== 3'd2) begin
         $display("FAIL pause_end: got cnt=%0d st=%0d want 5 2", cycle_count, run_state); bad++;
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (obs_vec() !== exp_vec()) begin
            $display("FAIL resume_cyc%0d: got %h want %h", i, obs_vec(), exp_vec()); bad++;
         end
         advance();
      end
      total++;
      if (cycle_count !== 32'd8 || run_state !== 3'd1) begin
         $display("FAIL resume_end: got cnt=%0d st=%0d want 8 1", cycle_count, run_state); bad++;
      end
   endtask

   task automatic test_soft_rst();
      restart();
      run_to(8);
      restart();
      total++;
      if (run_state !== 3'd0 || core_rst !== 1'b1 || cycle_count !== 32'd0) begin
         $display("FAIL soft_hold: got st=%0d rst=%b cnt=%0d want 0 1 0", run_state, core_rst, cycle_count); bad++;
      end
      advance();
      advance();
      total++;
      if (run_state !== 3'd1 || core_rst !== 1'b0) begin
         $display("FAIL soft_rerun: got st=%0d rst=%b want 1 0", run_state, core_rst); bad++;
      end
      run_to(2);
      halt_in = 1'b1;
      advance();
      halt_in = 1'b0;
      restart();
      total++;
      if (done !== 1'b0 || timeout !== 1'b0 || run_state !== 3'd0 || cycle_count !== 32'd0) begin
         $display("FAIL soft_from_halt: got done=%b to=%b st=%0d cnt=%0d want 0 0 0 0", done, timeout, run_state, cycle_count); bad++;
      end
   endtask

   task automatic test_async_reset();
      restart();
      run_to(4);
      pause = 1'b1;
      advance();
      advance();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      total++;
      if (obs_vec() !== exp_vec() || run_state !== 3'd0 || cycle_count !== 32'd0 || core_rst !== 1'b1) begin
         $display("FAIL async_reset: got %h want %h", obs_vec(), exp_vec()); bad++;
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         pause = 1'($urandom_range(0, 1)); step = 1'($urandom_range(0, 1)); halt_in = 1'($urandom_range(0, 1));
         @(negedge clk);
         total++;
         if (obs_vec() !== exp_vec()) begin
            $display("FAIL hold_toggle%0d: got %h want %h", i, obs_vec(), exp_vec()); bad++;
         end
         advance();
      end
      pause = 1'b0; step = 1'b0; halt_in = 1'b0;
   endtask

   task automatic test_random();
      restart();
      for (int i = 0; i < 400; i++) begin
         soft_rst = ($urandom_range(0, 29) == 0);
         pause    = ($urandom_range(0, 3) == 0);
         step     = 1'($urandom_range(0, 1));
         halt_in  = ($urandom_range(0, 39) == 0);
         @(negedge clk);
         total++;
         if (obs_vec() !== exp_vec()) begin
            $display("FAIL random_cyc%0d: got %h want %h", i, obs_vec(), exp_vec()); bad++;
         end
         advance();
      end
      soft_rst = 1'b0; pause = 1'b0; step = 1'b0; halt_in = 1'b0;
   endtask

   initial begin
      test_reset();
      test_startup();
      test_timeout();
      test_halt(5);
      test_halt(14);
      test_pause_step();
      test_soft_rst();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
